// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the draw source scheduler.
// Holds the pass FSM state encoding and the counter widths.
package draw_sched_pkg;

  localparam int MAX_SOURCES = 16;
  localparam int DROP_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUF = 3'd1,
    ST_SCAN     = 3'd2,
    ST_START    = 3'd3,
    ST_DRAW     = 3'd4,
    ST_FINISH   = 3'd5
  } sched_state_t;

  // Select width for n sources; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_picker.sv
// Combinational priority picker: index of the lowest set bit of a mask.
// The lowest index wins, which gives painter's order (background first).
module lowest_set_picker #(
  parameter int N     = 2,
  parameter int SRC_W = 1
) (
  input  logic [N-1:0]     pending_i,
  output logic             valid_o,
  output logic [SRC_W-1:0] index_o
);

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    // Walk downward so the last match written is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        valid_o = 1'b1;
        index_o = SRC_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_source_scheduler.sv
// Per-frame sequencer for the frame-buffer write port among draw units.
// Grants sources lowest index first, counts dropped frames, flags hung units.
module draw_source_scheduler
  import draw_sched_pkg::*;
#(
  parameter  int NUM_SOURCES = 2,
  parameter  int TIMEOUT_CYC = 400000,
  localparam int SRC_W       = src_w(NUM_SOURCES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame,
  input  logic                   buffer_ready,
  input  logic [NUM_SOURCES-1:0] src_req,
  input  logic [NUM_SOURCES-1:0] src_done,
  output logic [NUM_SOURCES-1:0] src_start,
  output logic [NUM_SOURCES-1:0] src_grant,
  output logic [SRC_W-1:0]       write_source_sel,
  output logic                   pass_busy,
  output logic                   pass_done,
  output logic [DROP_CNT_W-1:0]  dropped_frames,
  output logic                   timeout_err
);

  localparam bit          TMO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYC - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  sched_state_t           state_q, state_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [SRC_W-1:0]       sel_q, sel_d;
  logic [31:0]            tmo_cnt_q, tmo_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic                   tmo_err_q, tmo_err_d;

  logic                   pick_valid;
  logic [SRC_W-1:0]       pick_idx;
  logic [NUM_SOURCES-1:0] sel_onehot;
  logic                   grant_active;
  logic                   done_hit;
  logic                   timeout_hit;

  lowest_set_picker #(
    .N     (NUM_SOURCES),
    .SRC_W (SRC_W)
  ) u_picker (
    .pending_i (pending_q),
    .valid_o   (pick_valid),
    .index_o   (pick_idx)
  );

  assign sel_onehot   = NUM_SOURCES'(1) << sel_q;
  assign grant_active = (state_q == ST_START) || (state_q == ST_DRAW);
  assign done_hit     = |(src_done & sel_onehot);
  assign timeout_hit  = TMO_EN && (tmo_cnt_q >= TMO_LIMIT);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      ST_IDLE: begin
        if (frame) begin
          pending_d = src_req;
          state_d   = ST_WAIT_BUF;
        end
      end
      // An empty request set skips the buffer wait and closes the pass at once.
      ST_WAIT_BUF: begin
        if (pending_q == '0) state_d = ST_FINISH;
        else if (buffer_ready) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = ST_START;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_START, ST_DRAW: begin
        if (done_hit) begin
          pending_d = pending_q & ~sel_onehot;
          state_d   = ST_SCAN;
        end else if (timeout_hit) begin
          pending_d = pending_q & ~sel_onehot;
          tmo_err_d = 1'b1;
          state_d   = ST_SCAN;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counter is zero during START, so the grant lasts exactly TIMEOUT_CYC cycles.
  always_comb begin
    tmo_cnt_d = grant_active ? tmo_cnt_q + 32'd1 : 32'd0;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame && (state_q != ST_IDLE) && (drop_cnt_q != DROP_MAX))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      sel_q      <= '0;
      tmo_cnt_q  <= '0;
      drop_cnt_q <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      tmo_cnt_q  <= tmo_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign src_grant        = grant_active ? sel_onehot : '0;
  assign src_start        = (state_q == ST_START) ? sel_onehot : '0;
  assign write_source_sel = sel_q;
  assign pass_busy        = (state_q != ST_IDLE);
  assign pass_done        = (state_q == ST_FINISH);
  assign dropped_frames   = drop_cnt_q;
  assign timeout_err      = tmo_err_q;

endmodule

// File: tb/tb_draw_source_scheduler.sv
// Scoreboard bench for draw_source_scheduler (2 sources, 100-cycle timeout).
// Stimulus pushes expected start/pass_done events; a monitor pops and compares them.
module tb_draw_source_scheduler;

  logic       clk;
  logic       rst;
  logic       frame;
  logic       buffer_ready;
  logic [1:0] src_req;
  logic [1:0] src_done;
  logic [1:0] src_start;
  logic [1:0] src_grant;
  logic       write_source_sel;
  logic       pass_busy;
  logic       pass_done;
  logic [7:0] dropped_frames;
  logic       timeout_err;

  draw_source_scheduler #(
    .NUM_SOURCES (2),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frame            (frame),
    .buffer_ready     (buffer_ready),
    .src_req          (src_req),
    .src_done         (src_done),
    .src_start        (src_start),
    .src_grant        (src_grant),
    .write_source_sel (write_source_sel),
    .pass_busy        (pass_busy),
    .pass_done        (pass_done),
    .dropped_frames   (dropped_frames),
    .timeout_err      (timeout_err)
  );

  typedef struct {
    bit         is_done;
    logic [1:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Monitor: every start pulse or pass_done must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (src_start != 2'b00 || pass_done)) begin
      exp_t e;
      exp_t a;
      a.is_done = pass_done;
      a.data    = pass_done ? {1'b0, write_source_sel} : src_start;
      a.cyc     = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got done=%0b data=%b cyc=%0d, required no event", a.is_done, a.data, a.cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done !== a.is_done || e.data !== a.data || e.cyc !== a.cyc) begin
          bad++;
          $display("FAIL event: got done=%0b data=%b cyc=%0d, required done=%0b data=%b cyc=%0d",
                   a.is_done, a.data, a.cyc, e.is_done, e.data, e.cyc);
        end else begin
          $display("event ok: done=%0b data=%b cyc=%0d", a.is_done, a.data, a.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check ok: %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push(input bit is_done, input logic [1:0] data, input int at);
    exp_t e;
    e.is_done = is_done;
    e.data    = data;
    e.cyc     = at;
    exp_q.push_back(e);
  endtask

  task automatic do_frame(output int c);
    c = cyc;
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic pulse_done(input logic [1:0] v);
    src_done = v;
    tick();
    src_done = 2'b00;
  endtask

  // Full two-source pass with buffer ready; includes a stray done on the idle source.
  task automatic run_pass_11();
    int c, d0, s1, d1;
    src_req      = 2'b11;
    buffer_ready = 1'b1;
    do_frame(c);
    push(1'b0, 2'b01, c + 3);
    tick_until(c + 3);
    check("grant0_at_start", {30'd0, src_grant}, 32'd1);
    d0 = c + 8;
    tick_until(d0);
    push(1'b0, 2'b10, d0 + 2);
    pulse_done(2'b01);
    s1 = d0 + 2;
    tick_until(s1 + 2);
    pulse_done(2'b01);
    tick();
    check("stray_done_ignored", {30'd0, src_grant}, 32'd2);
    d1 = s1 + 6;
    tick_until(d1);
    push(1'b1, 2'b01, d1 + 2);
    pulse_done(2'b10);
    tick_until(d1 + 4);
    check("sel_held_after_pass", {31'd0, write_source_sel}, 32'd1);
    check("grant_zero_after_pass", {30'd0, src_grant}, 32'd0);
    check("idle_not_busy", {31'd0, pass_busy}, 32'd0);
  endtask

  initial begin
    int c, r, s, gcnt;
    rst          = 1'b1;
    frame        = 1'b0;
    buffer_ready = 1'b0;
    src_req      = 2'b00;
    src_done     = 2'b00;
    tick();
    tick();
    check("rst_grant", {30'd0, src_grant}, 32'd0);
    check("rst_start", {30'd0, src_start}, 32'd0);
    check("rst_sel", {31'd0, write_source_sel}, 32'd0);
    check("rst_busy_done", {30'd0, pass_busy, pass_done}, 32'd0);
    check("rst_dropped", {24'd0, dropped_frames}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // Two sources, done in DRAW, painter's order.
    run_pass_11();

    // Only source 1 requested; done arrives in the START cycle itself.
    src_req = 2'b10;
    do_frame(c);
    push(1'b0, 2'b10, c + 3);
    push(1'b1, 2'b01, c + 5);
    tick_until(c + 3);
    pulse_done(2'b10);
    tick_until(c + 8);

    // Nothing requested: pass_done two cycles after the frame, no start.
    src_req = 2'b00;
    do_frame(c);
    push(1'b1, 2'b01, c + 2);
    tick_until(c + 6);

    // Buffer held busy for 50 cycles.
    src_req      = 2'b01;
    buffer_ready = 1'b0;
    do_frame(c);
    tick_until(c + 51);
    check("busy_in_wait_buf", {31'd0, pass_busy}, 32'd1);
    check("no_grant_in_wait_buf", {30'd0, src_grant}, 32'd0);
    r = cyc;
    buffer_ready = 1'b1;
    push(1'b0, 2'b01, r + 2);
    push(1'b1, 2'b00, r + 6);
    tick_until(r + 4);
    pulse_done(2'b01);
    tick_until(r + 10);
    check("no_timeout_yet", {31'd0, timeout_err}, 32'd0);

    // Source 1 hangs: grant held exactly 100 cycles.
    src_req = 2'b10;
    do_frame(c);
    s = c + 3;
    push(1'b0, 2'b10, s);
    push(1'b1, 2'b01, s + 101);
    tick_until(s);
    gcnt = 0;
    for (int k = 0; k < 110; k++) begin
      if (src_grant[1]) gcnt++;
      tick();
    end
    check("timeout_grant_cycles", gcnt, 32'd100);
    check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    check("dropped_before_flood", {24'd0, dropped_frames}, 32'd0);

    // 300 frames during a pass stalled on the buffer.
    src_req      = 2'b01;
    buffer_ready = 1'b0;
    do_frame(c);
    frame = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 99) check("dropped_after_100", {24'd0, dropped_frames}, 32'd100);
    end
    frame = 1'b0;
    tick();
    check("dropped_saturated", {24'd0, dropped_frames}, 32'd255);
    r = cyc;
    buffer_ready = 1'b1;
    push(1'b0, 2'b01, r + 2);
    push(1'b1, 2'b00, r + 4);
    tick_until(r + 2);
    pulse_done(2'b01);
    tick_until(r + 8);
    check("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a draw.
    src_req = 2'b11;
    do_frame(c);
    push(1'b0, 2'b01, c + 3);
    tick_until(c + 6);
    check("grant_before_rst", {30'd0, src_grant}, 32'd1);
    rst = 1'b1;
    #1;
    check("grant_drops_async", {30'd0, src_grant}, 32'd0);
    check("rst_clears_dropped", {24'd0, dropped_frames}, 32'd0);
    check("rst_clears_timeout", {31'd0, timeout_err}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_pass_11();

    tick_until(cyc + 5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
